// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two pipelined Wishbone masters (A, B) sharing one slave.
// A grant lasts a whole bus cycle; one IDLE cycle separates owners.
// Ports: i_clk, i_reset (sync, active high);
//   i_a_* / o_a_*, i_b_* / o_b_*: master cyc/stb/we/addr/data/sel
//     requests and stall/ack/err/data responses;
//   o_wb_* / i_wb_*: slave-side request and response.
// Option: define WB_ARBITER2_RR_EN for a round-robin tie-break;
//   otherwise A always wins ties.
module wb_arbiter2 #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic            o_a_err,
    output logic [DW-1:0]   o_a_data,
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic            o_b_err,
    output logic [DW-1:0]   o_b_data,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } owner_t;

    owner_t owner;
    logic   pick_a;
    logic   own_a;
    logic   own_b;

`ifdef WB_ARBITER2_RR_EN
    // last = 1 means B owned most recently, so A wins the next tie
    logic last;
    assign pick_a = last;
`else
    assign pick_a = 1'b1;
`endif

    assign own_a = (owner == OWN_A);
    assign own_b = (owner == OWN_B);

    // Release on cyc drop or on a slave error; never hand over directly
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            owner <= IDLE;
`ifdef WB_ARBITER2_RR_EN
            last  <= 1'b1;
`endif
        end else begin
            case (owner)
                IDLE: begin
                    if (i_a_cyc && (!i_b_cyc || pick_a))
                        owner <= OWN_A;
                    else if (i_b_cyc)
                        owner <= OWN_B;
                end
                OWN_A: begin
                    if (!i_a_cyc || (i_wb_err && o_wb_cyc)) begin
                        owner <= IDLE;
`ifdef WB_ARBITER2_RR_EN
                        last  <= 1'b0;
`endif
                    end
                end
                OWN_B: begin
                    if (!i_b_cyc || (i_wb_err && o_wb_cyc)) begin
                        owner <= IDLE;
`ifdef WB_ARBITER2_RR_EN
                        last  <= 1'b1;
`endif
                    end
                end
                default: owner <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        o_wb_sel  = '0;
        o_a_stall = 1'b1;
        o_a_ack   = 1'b0;
        o_a_err   = 1'b0;
        o_b_stall = 1'b1;
        o_b_ack   = 1'b0;
        o_b_err   = 1'b0;
        unique case (1'b1)
            own_a: begin
                o_wb_cyc  = i_a_cyc;
                o_wb_stb  = i_a_cyc & i_a_stb;
                o_wb_we   = i_a_we;
                o_wb_addr = i_a_addr;
                o_wb_data = i_a_data;
                o_wb_sel  = i_a_sel;
                o_a_stall = i_wb_stall;
                o_a_ack   = i_wb_ack & i_a_cyc;
                o_a_err   = i_wb_err & i_a_cyc;
            end
            own_b: begin
                o_wb_cyc  = i_b_cyc;
                o_wb_stb  = i_b_cyc & i_b_stb;
                o_wb_we   = i_b_we;
                o_wb_addr = i_b_addr;
                o_wb_data = i_b_data;
                o_wb_sel  = i_b_sel;
                o_b_stall = i_wb_stall;
                o_b_ack   = i_wb_ack & i_b_cyc;
                o_b_err   = i_wb_err & i_b_cyc;
            end
            default: ;
        endcase
    end

    // Each master qualifies read data with its own ack
    assign o_a_data = i_wb_data;
    assign o_b_data = i_wb_data;

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: scenario tasks with a scoreboard of slave-side
// transactions (we, addr, data) expected vs. accepted.
module tb_wb_arbiter2;

    localparam int AW = 5;
    localparam int DW = 32;

    typedef logic [AW+DW:0] txn_t;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic            i_a_cyc, i_a_stb, i_a_we;
    logic [AW-1:0]   i_a_addr;
    logic [DW-1:0]   i_a_data;
    logic [DW/8-1:0] i_a_sel;
    logic            o_a_stall, o_a_ack, o_a_err;
    logic [DW-1:0]   o_a_data;
    logic            i_b_cyc, i_b_stb, i_b_we;
    logic [AW-1:0]   i_b_addr;
    logic [DW-1:0]   i_b_data;
    logic [DW/8-1:0] i_b_sel;
    logic            o_b_stall, o_b_ack, o_b_err;
    logic [DW-1:0]   o_b_data;
    logic            o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]   o_wb_addr;
    logic [DW-1:0]   o_wb_data;
    logic [DW/8-1:0] o_wb_sel;
    logic            i_wb_stall, i_wb_ack, i_wb_err;
    logic [DW-1:0]   i_wb_data;

    int   n_vec = 0;
    int   n_err = 0;
    txn_t exp_q[$];
    txn_t acc_q[$];
    txn_t got, want;

    wb_arbiter2 #(.AW(AW), .DW(DW)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we),
        .i_a_addr(i_a_addr), .i_a_data(i_a_data), .i_a_sel(i_a_sel),
        .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err),
        .o_a_data(o_a_data),
        .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we),
        .i_b_addr(i_b_addr), .i_b_data(i_b_data), .i_b_sel(i_b_sel),
        .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err),
        .o_b_data(o_b_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack),
        .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
    );

    always #5 i_clk = ~i_clk;

    // Slave-side acceptance monitor feeding the scoreboard
    always @(posedge i_clk)
        if (o_wb_cyc && o_wb_stb && !i_wb_stall)
            acc_q.push_back({o_wb_we, o_wb_addr, o_wb_data});

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_a_cyc = 0; i_a_stb = 0; i_a_we = 0;
        i_a_addr = '0; i_a_data = '0; i_a_sel = '0;
        i_b_cyc = 0; i_b_stb = 0; i_b_we = 0;
        i_b_addr = '0; i_b_data = '0; i_b_sel = '0;
        i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0;
        i_wb_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_reset = 1;
        tick();
        tick();
        i_reset = 0;
        @(negedge i_clk);
        n_vec++;
        if ({o_wb_cyc, o_wb_stb, o_a_stall, o_b_stall} !== 4'b0011) begin
            n_err++;
            $display("FAIL reset_idle got=%b want=0011",
                     {o_wb_cyc, o_wb_stb, o_a_stall, o_b_stall});
        end
        n_vec++;
        if ({o_wb_we, o_wb_addr, o_wb_data, o_wb_sel} !== '0) begin
            n_err++;
            $display("FAIL reset_payload got=%h want=0",
                     {o_wb_we, o_wb_addr, o_wb_data, o_wb_sel});
        end
        tick();
        i_a_cyc = 1; i_a_stb = 1; i_a_we = 1;
        i_a_addr = 5'h03; i_a_data = 32'hDEADBEEF; i_a_sel = 4'hF;
        @(negedge i_clk);
        n_vec++;
        if ({o_a_stall, o_wb_stb} !== 2'b10) begin
            n_err++;
            $display("FAIL grant_wait got=%b want=10",
                     {o_a_stall, o_wb_stb});
        end
        tick();
        @(negedge i_clk);
        exp_q.push_back({1'b1, 5'h03, 32'hDEADBEEF});
        n_vec++;
        if ({o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel}
            !== {1'b1, 1'b1, 5'h03, 32'hDEADBEEF, 4'hF}) begin
            n_err++;
            $display("FAIL first_stb got=%h want=%h",
                     {o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel},
                     {1'b1, 1'b1, 5'h03, 32'hDEADBEEF, 4'hF});
        end
        tick();
        i_a_stb = 0; i_wb_ack = 1;
        @(negedge i_clk);
        n_vec++;
        if ({o_a_ack, o_b_ack} !== 2'b10) begin
            n_err++;
            $display("FAIL first_ack got=%b want=10", {o_a_ack, o_b_ack});
        end
        tick();
        i_wb_ack = 0; i_a_cyc = 0;
        tick();
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset_txn got=%h want=%h", got, want);
            end
        end
    endtask

    task automatic test_burst();
        int k = 0;
        int na = 0;
        int nb = 0;
        logic pend = 0;
        logic b_ok = 1;
        i_a_cyc = 1; i_a_we = 1; i_a_sel = 4'hF;
        tick();
        for (int c = 0; c < 12; c++) begin
            i_wb_stall = c[0];
            i_wb_ack = pend;
            i_a_stb = (k < 4);
            i_a_addr = 5'(k + 8);
            i_a_data = 32'hA0 + k;
            if (c == 2) i_b_cyc = 1;
            @(negedge i_clk);
            if (c >= 2 && !o_b_stall) b_ok = 0;
            if (o_a_ack) na++;
            if (o_b_ack) nb++;
            pend = i_a_stb && !o_a_stall;
            if (pend) begin
                exp_q.push_back({1'b1, i_a_addr, i_a_data});
                k++;
            end
            tick();
        end
        n_vec++;
        if (na !== 4 || nb !== 0) begin
            n_err++;
            $display("FAIL burst_acks got=%0d/%0d want=4/0", na, nb);
        end
        n_vec++;
        if (b_ok !== 1'b1) begin
            n_err++;
            $display("FAIL burst_b_stall got=%b want=1", b_ok);
        end
        i_a_cyc = 0; i_a_stb = 0; i_wb_stall = 0; i_wb_ack = 0;
        @(negedge i_clk);
        n_vec++;
        if ({o_wb_cyc, o_b_stall} !== 2'b01) begin
            n_err++;
            $display("FAIL release_m got=%b want=01", {o_wb_cyc, o_b_stall});
        end
        tick();
        @(negedge i_clk);
        n_vec++;
        if ({o_wb_cyc, o_a_stall, o_b_stall} !== 3'b011) begin
            n_err++;
            $display("FAIL release_gap got=%b want=011",
                     {o_wb_cyc, o_a_stall, o_b_stall});
        end
        tick();
        @(negedge i_clk);
        n_vec++;
        if ({o_wb_cyc, o_b_stall} !== 2'b10) begin
            n_err++;
            $display("FAIL b_grant got=%b want=10", {o_wb_cyc, o_b_stall});
        end
        i_b_cyc = 0;
        tick();
        tick();
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL burst_txn got=%h want=%h", got, want);
            end
        end
        n_vec++;
        if (acc_q.size() != 0) begin
            n_err++;
            $display("FAIL burst_extra got=%0d want=0", acc_q.size());
            acc_q.delete();
        end
    endtask

    task automatic test_tie();
        logic exp_a;
        for (int r = 0; r < 4; r++) begin
            i_a_cyc = 1; i_a_stb = 1; i_a_we = 0;
            i_a_addr = 5'h01; i_a_data = 32'hA;
            i_b_cyc = 1; i_b_stb = 1; i_b_we = 0;
            i_b_addr = 5'h02; i_b_data = 32'hB;
            tick();
`ifdef WB_ARBITER2_RR_EN
            exp_a = (r % 2 == 0);
`else
            exp_a = 1'b1;
`endif
            @(negedge i_clk);
            if (exp_a) exp_q.push_back({1'b0, 5'h01, 32'hA});
            else exp_q.push_back({1'b0, 5'h02, 32'hB});
            n_vec++;
            if ({o_a_stall, o_b_stall} !== (exp_a ? 2'b01 : 2'b10)) begin
                n_err++;
                $display("FAIL tie_grant%0d got=%b want=%b", r,
                         {o_a_stall, o_b_stall},
                         (exp_a ? 2'b01 : 2'b10));
            end
            tick();
            i_a_stb = 0; i_b_stb = 0;
            i_wb_ack = 1; i_wb_data = 32'h1000 + r;
            @(negedge i_clk);
            n_vec++;
            if ({o_a_ack, o_b_ack} !== (exp_a ? 2'b10 : 2'b01)) begin
                n_err++;
                $display("FAIL tie_ack%0d got=%b want=%b", r,
                         {o_a_ack, o_b_ack}, (exp_a ? 2'b10 : 2'b01));
            end
            tick();
            i_a_cyc = 0; i_b_cyc = 0; i_wb_ack = 0;
            tick();
        end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL tie_txn got=%h want=%h", got, want);
            end
        end
    endtask

    task automatic test_error();
        i_b_cyc = 1; i_b_stb = 1; i_b_we = 0;
        i_b_addr = 5'h04; i_b_data = 32'h44;
        tick();
        @(negedge i_clk);
        exp_q.push_back({1'b0, 5'h04, 32'h44});
        tick();
        i_b_addr = 5'h05; i_b_data = 32'h55; i_wb_ack = 1;
        @(negedge i_clk);
        exp_q.push_back({1'b0, 5'h05, 32'h55});
        n_vec++;
        if (o_b_ack !== 1'b1) begin
            n_err++;
            $display("FAIL err_first_ack got=%b want=1", o_b_ack);
        end
        tick();
        i_b_stb = 0; i_wb_ack = 0; i_wb_err = 1; i_a_cyc = 1;
        @(negedge i_clk);
        n_vec++;
        if ({o_b_err, o_a_err, o_b_ack} !== 3'b100) begin
            n_err++;
            $display("FAIL err_route got=%b want=100",
                     {o_b_err, o_a_err, o_b_ack});
        end
        tick();
        i_wb_err = 0; i_a_cyc = 0;
        @(negedge i_clk);
        n_vec++;
        if ({o_wb_cyc, o_a_stall, o_b_stall} !== 3'b011) begin
            n_err++;
            $display("FAIL err_idle got=%b want=011",
                     {o_wb_cyc, o_a_stall, o_b_stall});
        end
        tick();
        i_b_cyc = 0;
        tick();
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL err_txn got=%h want=%h", got, want);
            end
        end
    endtask

    task automatic test_abort();
        i_a_cyc = 1; i_a_stb = 1; i_a_we = 0;
        i_a_addr = 5'h06; i_a_data = 32'h66;
        tick();
        @(negedge i_clk);
        exp_q.push_back({1'b0, 5'h06, 32'h66});
        tick();
        i_a_addr = 5'h07; i_a_data = 32'h77;
        @(negedge i_clk);
        exp_q.push_back({1'b0, 5'h07, 32'h77});
        tick();
        i_a_cyc = 0; i_a_stb = 0;
        @(negedge i_clk);
        n_vec++;
        if ({o_wb_cyc, o_wb_stb} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_cyc got=%b want=00", {o_wb_cyc, o_wb_stb});
        end
        tick();
        i_wb_ack = 1;
        @(negedge i_clk);
        n_vec++;
        if ({o_a_ack, o_b_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_late_ack got=%b want=00",
                     {o_a_ack, o_b_ack});
        end
        tick();
        i_wb_ack = 0;
        tick();
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL abort_txn got=%h want=%h", got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        i_b_cyc = 1; i_b_stb = 1; i_b_we = 1;
        i_b_addr = 5'h09; i_b_data = 32'h99; i_b_sel = 4'h3;
        tick();
        @(negedge i_clk);
        exp_q.push_back({1'b1, 5'h09, 32'h99});
        n_vec++;
        if (o_b_stall !== 1'b0) begin
            n_err++;
            $display("FAIL mid_b_grant got=%b want=0", o_b_stall);
        end
        tick();
        i_reset = 1; i_b_addr = 5'h0A; i_b_data = 32'hAA;
        @(negedge i_clk);
        exp_q.push_back({1'b1, 5'h0A, 32'hAA});
        tick();
        i_reset = 0; i_a_cyc = 1;
        @(negedge i_clk);
        n_vec++;
        if ({o_wb_cyc, o_wb_stb, o_b_stall, o_a_stall} !== 4'b0011) begin
            n_err++;
            $display("FAIL mid_reset got=%b want=0011",
                     {o_wb_cyc, o_wb_stb, o_b_stall, o_a_stall});
        end
        tick();
        @(negedge i_clk);
        n_vec++;
        if ({o_a_stall, o_b_stall} !== 2'b01) begin
            n_err++;
            $display("FAIL post_reset_tie got=%b want=01",
                     {o_a_stall, o_b_stall});
        end
        idle_inputs();
        tick();
        tick();
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL mid_txn got=%h want=%h", got, want);
            end
        end
        n_vec++;
        if (acc_q.size() != 0) begin
            n_err++;
            $display("FAIL final_extra got=%0d want=0", acc_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_tie();
        test_error();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
